ram_byte_bridge: RTL and testbench
==================================

# ram_byte_bridge

Responder for the CPU data-RAM port: accepts word-wide requests (`ce`, `we`, `addr`, `sel`, write data), serialises them onto a byte-wide synchronous SRAM, and stalls the CPU until the access completes. It sits between `cpu` and external/off-chip byte memory in the SoC top level, in place of the single-cycle word RAM. Little-endian lane mapping; one memory byte per cycle.

## Interface

Parameters:
- `MEM_AW`, 17, byte-address width of the external memory.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce_i`  in  1  CPU request valid (from `ram_ce_o`).
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  32  CPU byte address; bits [1:0] are ignored, and lanes come from `sel_i`.
- `sel_i`  in  4  byte-lane enables; bit k selects `data[8k+7:8k]`.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data; unselected lanes read as 0.
- `stall_o`  out  1  CPU must hold the request stable while high.
- `mem_ce_o`  out  1  byte-memory chip enable.
- `mem_we_o`  out  1  byte-memory write enable.
- `mem_addr_o`  out  MEM_AW  byte address `{addr_i[MEM_AW-1:2], lane[1:0]}`, taken from the latched request.
- `mem_data_o`  out  8  byte write data.
- `mem_data_i`  in  8  byte read data, valid one cycle after the issue cycle (synchronous read).
- `err_o`  out  1  present only with `RAM_BRIDGE_SEL_CHK_EN`.

## Operation

- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - With `ce_i`=1: latch `we`, `addr`, `sel`, `data`. Set the pending-lane mask to `sel_i`.
  - If the mask is non-zero, go to ISSUE. If `sel_i`=0, go directly to DONE.
- **ISSUE**
  - Each cycle, serve the lowest set lane k of the pending mask, then clear it.
  - Drive `mem_ce_o`=1, `mem_we_o`=latched `we`, `mem_addr_o` low bits=k, `mem_data_o`=`data[8k+7:8k]`.
  - After the last lane: a write goes to DONE; a read goes to WAIT.
- **Read capture:** `mem_data_i` is captured into byte k of the read buffer in the cycle after lane k is issued. This happens in ISSUE for earlier lanes and in WAIT for the last lane.
- **WAIT:** captures the last byte; `mem_ce_o`=0. Go to DONE.
- **DONE**
  - `stall_o`=0 and `data_o` holds the completed read buffer; writes leave the buffer cleared.
  - Always return to IDLE. A new request is only recognised in IDLE, the cycle after DONE.
- **Read buffer:** cleared to 0 when a request is latched, so unselected lanes read 0.
- **`stall_o`:** combinational, = `ce_i` in IDLE; =1 in ISSUE/WAIT; =0 in DONE.
- **`ce_i` dropped mid-access:** protocol violation. The latched request still completes; no abort.
- **Reset asserted mid-access:** immediate return to IDLE. `mem_ce_o`/`mem_we_o` go to 0 asynchronously and the partial access is abandoned.

## Timing

- Reset values: `data_o`=0, `stall_o`=0 (`ce_i`=0 in IDLE), `mem_ce_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `err_o`=0.
- With n = popcount(`sel_i`) and request first seen in cycle 0:
  - Write: ISSUE in cycles 1..n, DONE in cycle n+1; `stall_o` high for cycles 0..n.
  - Read: ISSUE in cycles 1..n, WAIT in n+1, DONE in n+2.
- Full-word write completes in cycle 5; full-word read completes in cycle 6. `sel_i`=0 reaches DONE in cycle 1.
- No two memory cycles overlap. `mem_*` outputs are decoded from registered state and counters, with no `ce_i`→`mem_*` combinational path.

## Configuration

- Macro: `RAM_BRIDGE_SEL_CHK_EN`.
- **Defined:** `err_o` exists. `sel_i` must be one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111; otherwise:
  - no memory cycle is issued;
  - IDLE goes straight to DONE;
  - `data_o`=0 and `err_o`=1 during that DONE cycle only.
  - `sel_i`=0 is also legal, with no error.
- **Undefined:** no `err_o` port. Any `sel_i` pattern is executed lane by lane as above.

## Test plan

- **Reset:** `rst`=0 with random inputs → all outputs 0. Release `rst`; `ce_i`=0 → `stall_o`=0 and no `mem_ce_o` pulses.
- **Full-word write then read:** write `addr`=0x100, `sel`=1111, `data`=0xDEADBEEF → bytes EF, BE, AD, DE written at mem addr 0x100–0x103 in cycles 1–4, DONE in cycle 5. Read back the same address → `data_o`=0xDEADBEEF in cycle 6; `stall_o` high for cycles 0–5.
- **Byte read, lane 2:** `sel`=0100 at 0x100 → exactly one `mem_ce_o` cycle at mem addr 0x102; `data_o`=0x00AD0000 in DONE (cycle 3).
- **Halfword write:** `sel`=1100, `data`=0x12340000 → two writes: 0x34 to 0x102, 0x12 to 0x103. Addresses 0x100/0x101 are untouched.
- **Reset mid-read:** assert `rst` during ISSUE of a full-word read → `mem_ce_o` drops immediately. After release the FSM is in IDLE, and a new request completes normally.
- **With `RAM_BRIDGE_SEL_CHK_EN`:** `sel`=0101 → no `mem_ce_o`, `err_o`=1 for exactly one cycle (cycle 1), `data_o`=0. `sel`=0011 → `err_o` stays 0.

Source files
------------

// File: rtl/ram_byte_bridge.sv
// ram_byte_bridge: word-wide CPU data-RAM responder that serialises each
// request into byte cycles on a synchronous byte-wide SRAM and stalls the
// CPU until the access is complete. Lanes are served lowest-first, one per
// cycle. Read data arrives one cycle after its issue cycle.
// Optional build macro RAM_BRIDGE_SEL_CHK_EN adds err_o. With it, a request
// with an unsupported byte-lane pattern is rejected without any memory cycle.
module ram_byte_bridge #(
  parameter int MEM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  input  logic [7:0]        mem_data_i
`ifdef RAM_BRIDGE_SEL_CHK_EN
  ,
  output logic              err_o
`endif
);

  // state  | meaning
  // IDLE   | waiting for ce_i; latches the request when it is seen
  // ISSUE  | one byte cycle per pending lane, lowest lane first
  // WAIT   | read only: captures the byte of the last issued lane
  // DONE   | stall released for one cycle, data_o holds the result
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [MEM_AW-3:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        pend_q, pend_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              cap_q, cap_d;
  logic [1:0]        cap_lane_q, cap_lane_d;
  logic [1:0]        lane;
  logic              issue;
  logic              addr_unused;

`ifdef RAM_BRIDGE_SEL_CHK_EN
  logic err_q, err_d;

  // Byte, aligned halfword, full word or nothing are the supported patterns.
  function automatic logic sel_legal(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: sel_legal = 1'b1;
      default:                   sel_legal = 1'b0;
    endcase
  endfunction
`endif

  // Word-offset bits and bits above the memory window play no part.
  assign addr_unused = ^{addr_i[31:MEM_AW], addr_i[1:0]};

  // Pick the lowest pending lane; this is the lane served this cycle.
  always_comb begin
    lane = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pend_q[k]) lane = 2'(k);
    end
  end

  // Next-state, request latching and read-byte capture.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pend_d     = pend_q;
    rbuf_d     = rbuf_q;
    cap_d      = 1'b0;
    cap_lane_d = cap_lane_q;
`ifdef RAM_BRIDGE_SEL_CHK_EN
    err_d      = err_q;
`endif

    // The byte issued last cycle is on mem_data_i now.
    if (cap_q) rbuf_d[{cap_lane_q, 3'b000} +: 8] = mem_data_i;

    case (state_q)
      S_IDLE: begin
        if (ce_i) begin
          we_d    = we_i;
          addr_d  = addr_i[MEM_AW-1:2];
          data_d  = data_i;
          pend_d  = sel_i;
          rbuf_d  = 32'h0;
          state_d = (sel_i == 4'b0000) ? S_DONE : S_ISSUE;
`ifdef RAM_BRIDGE_SEL_CHK_EN
          err_d   = 1'b0;
          if (!sel_legal(sel_i)) begin
            pend_d  = 4'b0000;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_ISSUE: begin
        pend_d     = pend_q & ~(4'b0001 << lane);
        cap_d      = ~we_q;
        cap_lane_d = lane;
        if (pend_d == 4'b0000) state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'h0;
      pend_q     <= 4'b0000;
      rbuf_q     <= 32'h0;
      cap_q      <= 1'b0;
      cap_lane_q <= 2'd0;
`ifdef RAM_BRIDGE_SEL_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      rbuf_q     <= rbuf_d;
      cap_q      <= cap_d;
      cap_lane_q <= cap_lane_d;
`ifdef RAM_BRIDGE_SEL_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Memory strobes come only from registered state, never from ce_i.
  always_comb begin
    issue      = (state_q == S_ISSUE);
    mem_ce_o   = issue;
    mem_we_o   = issue & we_q;
    mem_addr_o = issue ? {addr_q, lane} : '0;
    mem_data_o = issue ? data_q[{lane, 3'b000} +: 8] : 8'h00;
    stall_o    = (state_q == S_IDLE) ? ce_i : (state_q != S_DONE);
    data_o     = rbuf_q;
  end

`ifdef RAM_BRIDGE_SEL_CHK_EN
  // Rejection is flagged only during the DONE cycle of that request.
  always_comb begin
    err_o = err_q & (state_q == S_DONE);
  end
`endif

endmodule

// File: tb/tb_ram_byte_bridge.sv
// Bench for ram_byte_bridge. It uses a byte SRAM model and a reference
// memory image. Each request's expected cycle-by-cycle behaviour is derived
// from its lane list. A single compare process checks the DUT every cycle.
module tb_ram_byte_bridge;
  localparam int MEM_AW = 17;
  localparam int WIN    = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ce_i = 1'b0, we_i = 1'b0;
  logic [31:0]       addr_i = '0, data_i = '0;
  logic [3:0]        sel_i = '0;
  logic [31:0]       data_o;
  logic              stall_o, mem_ce_o, mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [7:0]        mem_data_o, mem_data_i;
`ifdef RAM_BRIDGE_SEL_CHK_EN
  logic              err_o;
`endif

  ram_byte_bridge #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
`ifdef RAM_BRIDGE_SEL_CHK_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  // Synchronous-read byte SRAM (the external device).
  logic [7:0] sram [0:WIN-1];
  logic [7:0] rd_q;
  assign mem_data_i = rd_q;
  initial begin
    for (int i = 0; i < WIN; i++) sram[i] = init_byte(i);
    rd_q = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_ce_o) begin
        if (mem_we_o) sram[mem_addr_o[11:0]] = mem_data_o;
        else rd_q <= sram[mem_addr_o[11:0]];
      end
    end
  end

  // Reference image of what the memory must contain.
  logic [7:0] ref_mem [0:WIN-1];

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // Expected values for the current cycle, published by the driver.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_ce, exp_we, exp_done, exp_err;
  logic [16:0] exp_addr;
  logic [7:0]  exp_wdata;
  logic [31:0] exp_data;

  // Compare process: every cycle the expectations are meaningful.
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall_o", stall_o, exp_stall);
      chk("mem_ce_o", mem_ce_o, exp_ce);
      if (exp_ce) begin
        chk("mem_we_o", mem_we_o, exp_we);
        chk("mem_addr_o", mem_addr_o, exp_addr);
        if (exp_we) chk("mem_data_o", mem_data_o, exp_wdata);
      end else begin
        chk("mem_we_o_quiet", mem_we_o, 1'b0);
      end
      if (exp_done) chk("data_o_done", data_o, exp_data);
`ifdef RAM_BRIDGE_SEL_CHK_EN
      chk("err_o", err_o, exp_err);
`endif
    end
  end

  function automatic logic sel_ok(input logic [3:0] s);
`ifdef RAM_BRIDGE_SEL_CHK_EN
    return s inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0011, 4'b1100, 4'b1111};
`else
    return 1'b1;
`endif
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ce_i = 1'b0; we_i = $urandom; sel_i = 4'($urandom);
      addr_i = $urandom; data_i = $urandom;
      exp_stall = 0; exp_ce = 0; exp_we = 0; exp_done = 0; exp_err = 0;
      exp_valid = 1;
      @(posedge clk); #1;
    end
  endtask

  // One request from its first cycle (IDLE) through DONE. If drop is set,
  // ce_i falls and the other inputs wander after cycle 0.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input logic drop,
                        output logic [31:0] got, output int nstall, output int nce);
    int lanes[$];
    int n, done_c, base;
    logic bad;
    logic [31:0] rd_word;
    bad = !sel_ok(sel);
    for (int k = 0; k < 4; k++) if (sel[k] && !bad) lanes.push_back(k);
    n = lanes.size();
    done_c = (n == 0) ? 1 : (we ? n + 1 : n + 2);
    base = int'(addr[11:2]) * 4;
    rd_word = 0;
    foreach (lanes[i]) rd_word[8*lanes[i] +: 8] = ref_mem[base + lanes[i]];
    nstall = 0; nce = 0; got = 0;
    for (int c = 0; c <= done_c; c++) begin
      if (c == 0 || !drop) begin
        ce_i = 1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
      end else begin
        ce_i = 0; we_i = $urandom; addr_i = $urandom; sel_i = 4'($urandom); data_i = $urandom;
      end
      exp_stall = (c < done_c);
      exp_ce    = (c >= 1 && c <= n);
      exp_we    = we;
      exp_addr  = 17'(addr[16:2] * 4);
      exp_wdata = 0;
      if (exp_ce) begin
        exp_addr  = exp_addr + 17'(lanes[c-1]);
        exp_wdata = data[8*lanes[c-1] +: 8];
      end
      exp_done  = (c == done_c);
      exp_data  = we ? 32'h0 : rd_word;
      exp_err   = exp_done && bad;
      exp_valid = 1;
      @(negedge clk);
      if (stall_o) nstall++;
      if (mem_ce_o) nce++;
      if (exp_done) got = data_o;
      @(posedge clk); #1;
    end
    if (we) foreach (lanes[i]) ref_mem[base + lanes[i]] = data[8*lanes[i] +: 8];
    ce_i = 0;
  endtask

  logic [31:0] got;
  int ns, nc, nbad;

  initial begin
    for (int i = 0; i < WIN; i++) ref_mem[i] = init_byte(i);

    // Reset held with random inputs (ce_i low): all outputs at zero.
    for (int i = 0; i < 4; i++) begin
      we_i = $urandom; sel_i = 4'($urandom); addr_i = $urandom; data_i = $urandom;
      @(negedge clk);
      chk("rst_data_o", data_o, 0);
      chk("rst_stall_o", stall_o, 0);
      chk("rst_mem_ce", mem_ce_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_data", mem_data_o, 0);
`ifdef RAM_BRIDGE_SEL_CHK_EN
      chk("rst_err_o", err_o, 0);
`endif
    end
    @(posedge clk); #1 rst = 1;
    idle(4);

    // Directed, with hand-computed literals.
    do_req(1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, got, ns, nc);
    chk("wr_full_stall_cycles", ns, 5);
    chk("wr_full_mem_cycles", nc, 4);
    chk("wr_full_bytes", {sram[12'h103], sram[12'h102], sram[12'h101], sram[12'h100]}, 32'hDEADBEEF);
    do_req(0, 32'h100, 4'b1111, 0, 0, got, ns, nc);
    chk("rd_full_data", got, 32'hDEADBEEF);
    chk("rd_full_stall_cycles", ns, 6);
    do_req(0, 32'h100, 4'b0100, 0, 0, got, ns, nc);
    chk("rd_lane2_data", got, 32'h00AD0000);
    chk("rd_lane2_mem_cycles", nc, 1);
    chk("rd_lane2_stall_cycles", ns, 3);
    do_req(1, 32'h100, 4'b1100, 32'h12340000, 0, got, ns, nc);
    chk("wr_half_mem_cycles", nc, 2);
    chk("wr_half_bytes", {sram[12'h103], sram[12'h102], sram[12'h101], sram[12'h100]}, 32'h1234BEEF);
    idle(2);
    do_req(0, 32'h100, 4'b1111, 0, 0, got, ns, nc);
    chk("rd_after_half", got, 32'h1234BEEF);
    do_req(0, 32'h104, 4'b0000, 0, 0, got, ns, nc);
    chk("sel0_stall_cycles", ns, 1);
    chk("sel0_mem_cycles", nc, 0);
    do_req(0, 32'h100, 4'b0101, 0, 0, got, ns, nc);
`ifdef RAM_BRIDGE_SEL_CHK_EN
    chk("sel0101_mem_cycles", nc, 0);
    chk("sel0101_data", got, 0);
`else
    chk("sel0101_mem_cycles", nc, 2);
    chk("sel0101_data", got, 32'h00340000 | 32'h000000EF);
`endif
    do_req(0, 32'h100, 4'b0011, 0, 0, got, ns, nc);
    chk("sel0011_data", got, 32'h0000BEEF);

    // Reset during ISSUE of a full-word read.
    exp_valid = 0;
    ce_i = 1; we_i = 0; addr_i = 32'h200; sel_i = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_pre_ce", mem_ce_o, 1);
    ce_i = 0;
    #1 rst = 0;
    #1;
    chk("midrst_mem_ce", mem_ce_o, 0);
    chk("midrst_mem_we", mem_we_o, 0);
    chk("midrst_stall", stall_o, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1;
    idle(1);
    do_req(0, 32'h200, 4'b1111, 0, 0, got, ns, nc);
    chk("post_rst_rd", got, {ref_mem[12'h203], ref_mem[12'h202], ref_mem[12'h201], ref_mem[12'h200]});
    chk("post_rst_stall_cycles", ns, 6);

    // Randomized traffic in a 4 KB window with ignored high/low address bits.
    for (int t = 0; t < 300; t++) begin
      do_req($urandom_range(0, 1), ($urandom & 32'hFFFE_0FFC) | ($urandom & 32'h3),
             4'($urandom), $urandom, ($urandom_range(0, 4) == 0), got, ns, nc);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    exp_valid = 0;

    nbad = 0;
    for (int i = 0; i < WIN; i++) if (sram[i] !== ref_mem[i]) nbad++;
    chk("mem_image_bad_bytes", nbad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
